// File: rtl/div_pkg.sv
// Shared types and defaults for the programmable clock divider controller.
package div_pkg;

   // Default half-period counter width; max divide ratio is 2*2^DEF_CNT_W.
   localparam int DEF_CNT_W = 8;

   // Half-period code loaded at reset (1 -> divide-by-4).
   localparam int DEF_HALF = 1;

   // Controller sequencing states.
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      STOPPING = 2'd2
   } div_state_t;

endpackage

// File: rtl/div_core.sv
// Divider datapath: half-period counter plus the clock_output toggle flop.
// 'clear' forces the output low and the counter to zero; it wins over 'run'.
// 'rise' is a registered pulse coinciding with the 0->1 edge of clock_output.
// 'fall' is a combinational strobe that is high in the cycle whose closing
// edge takes clock_output 1->0, so the controller can swap ratios on it.
module div_core
   import div_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clock_input,
   input  logic             reset,
   input  logic             run,
   input  logic             clear,
   input  logic [CNT_W-1:0] half,
   output logic             clock_output,
   output logic             rise,
   output logic             fall
);

   logic [CNT_W-1:0] cnt;
   logic             at_end;

   // Current phase ends when the counter reaches the half-period code.
   // Equality compare only, so half = all-ones never wraps the counter.
   assign at_end = (cnt == half);

   // Boundary strobe: the coming edge ends a high phase.
   assign fall = run && !clear && at_end && clock_output;

   // Counter, toggle flop and rise pulse.
   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clock_input or negedge reset) begin
      if (!reset) begin
         cnt          <= '0;
         clock_output <= 1'b0;
         rise         <= 1'b0;
      end else if (clear) begin
         cnt          <= '0;
         clock_output <= 1'b0;
         rise         <= 1'b0;
      end else if (run) begin
         rise <= at_end && !clock_output;
         if (at_end) begin
            cnt          <= '0;
            clock_output <= !clock_output;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end else begin
         rise <= 1'b0;
      end
   end

endmodule

// File: rtl/div_ctrl.sv
// Run-time controller for the programmable clock divider.
// Sequences start/stop of the divided clock and takes divide-ratio updates
// over a valid/ready handshake. Ratio changes and stops only land on period
// boundaries (the 1->0 edge of clock_output), so no runt phase is produced.
module div_ctrl
   import div_pkg::*;
#(
   parameter int CNT_W        = DEF_CNT_W,
   parameter int DEFAULT_HALF = DEF_HALF
) (
   input  logic             clock_input,
   input  logic             reset,
   input  logic             enable,
   input  logic             cfg_valid,
   input  logic [CNT_W-1:0] cfg_half,
   output logic             cfg_ready,
   output logic             clock_output,
   output logic             tick,
   output logic             busy,
   output logic             pending
);

   div_state_t       state;
   logic [CNT_W-1:0] active_half;
   logic [CNT_W-1:0] staged_half;
   logic             core_run;
   logic             core_clear;
   logic             core_fall;
   logic             accept;
   logic             apply_staged;

   // Handshake transfer this cycle.
   assign accept = cfg_valid && cfg_ready;

   // A staged ratio lands on the next high-to-low boundary, or straight away
   // if the divider already stopped with the clock low (no boundary pending).
   assign apply_staged = pending && (core_fall || (state == IDLE));

   // Decide whether the core counts or is held cleared this cycle.
   // NOTE: both outputs get a default before the case so no latch is inferred.
   always_comb begin
      core_run   = 1'b0;
      core_clear = 1'b0;
      unique case (state)
         IDLE: core_clear = 1'b1;
         // Keep counting while enabled, or while finishing a high phase;
         // a stop requested during a low phase clears immediately.
         RUN: begin
            if (enable || clock_output) core_run = 1'b1;
            else                        core_clear = 1'b1;
         end
         STOPPING: core_run = 1'b1;
         default:  core_clear = 1'b1;
      endcase
   end

   div_core #(
      .CNT_W (CNT_W)
   ) u_core (
      .clock_input  (clock_input),
      .reset        (reset),
      .run          (core_run),
      .clear        (core_clear),
      .half         (active_half),
      .clock_output (clock_output),
      .rise         (tick),
      .fall         (core_fall)
   );

   // FSM, ratio registers and registered status outputs.
   always_ff @(posedge clock_input or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         busy        <= 1'b0;
         pending     <= 1'b0;
         cfg_ready   <= 1'b1;
         active_half <= CNT_W'(DEFAULT_HALF);
         staged_half <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (enable) begin
                  state <= RUN;
                  busy  <= 1'b1;
               end
            end
            RUN: begin
               if (!enable) begin
                  // Low phase (or high phase ending right now): stop at once.
                  if (!clock_output || core_fall) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state <= STOPPING;
                  end
               end
            end
            // enable is ignored here; it is looked at again from IDLE.
            STOPPING: begin
               if (core_fall) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase

         // Ratio update. accept needs pending=0, so it never collides with
         // apply_staged; an accept on a boundary cycle waits for the next one.
         if (apply_staged) begin
            active_half <= staged_half;
            pending     <= 1'b0;
            cfg_ready   <= 1'b1;
         end else if (accept) begin
            if (state == IDLE) begin
               active_half <= cfg_half;
            end else begin
               staged_half <= cfg_half;
               pending     <= 1'b1;
               cfg_ready   <= 1'b0;
            end
         end
      end
   end

endmodule
